// File: rtl/motor_command_arbiter_pkg.sv
// Shared types and constants for the motor command arbiter and its slew limiters.
package motor_command_arbiter_pkg;

  typedef enum logic [1:0] {
    FAILSAFE = 2'd0,
    HOST     = 2'd1,
    RC       = 2'd2,
    PAUSED   = 2'd3
  } source_t;

  localparam logic [7:0]  NEUTRAL_WIDTH     = 8'd127;
  localparam int unsigned FRAME_CYCLES_20MS = 5100;

  // One wheel of the RC mix: throttle +/- (steer - 127), clamped into the 8-bit width range.
  function automatic logic [7:0] rc_mix(input logic [7:0] thr, input logic [7:0] steer,
                                        input logic add_steer);
    logic signed [9:0] sum;
    if (add_steer) begin
      sum = $signed({2'b00, thr}) + $signed({2'b00, steer}) - 10'sd127;
    end else begin
      sum = $signed({2'b00, thr}) - $signed({2'b00, steer}) + 10'sd127;
    end
    if (sum < 10'sd0) begin
      return 8'd0;
    end else if (sum > 10'sd255) begin
      return 8'd255;
    end else begin
      return sum[7:0];
    end
  endfunction

endpackage

// File: rtl/motor_command_arbiter_if.sv
// Command/status bundle between the register/RC front end and the motor arbiter.
interface motor_command_arbiter_if;
  logic       pause;
  logic       host_strobe;
  logic [7:0] host_left;
  logic [7:0] host_right;
  logic [7:0] rc_throttle;
  logic [7:0] rc_steer;
  logic [7:0] rc_mode;
  logic       rc_throttle_valid;
  logic       rc_steer_valid;
  logic       rc_mode_valid;
  logic [7:0] width_left;
  logic [7:0] width_right;
  logic [1:0] source;
  logic       frame_tick;

  modport master (
    output pause, host_strobe, host_left, host_right,
    output rc_throttle, rc_steer, rc_mode,
    output rc_throttle_valid, rc_steer_valid, rc_mode_valid,
    input  width_left, width_right, source, frame_tick
  );

  modport slave (
    input  pause, host_strobe, host_left, host_right,
    input  rc_throttle, rc_steer, rc_mode,
    input  rc_throttle_valid, rc_steer_valid, rc_mode_valid,
    output width_left, width_right, source, frame_tick
  );
endinterface

// File: rtl/motor_command_arbiter_slew_limiter.sv
// One PWM width channel: moves at most MAX_STEP toward its target per frame tick,
// or snaps to neutral immediately when forced.
module motor_command_arbiter_slew_limiter #(
  parameter logic [7:0] MAX_STEP = 8'd8,
  parameter logic [7:0] NEUTRAL  = 8'd127
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       tick_i,
  input  logic       force_neutral_i,
  input  logic [7:0] target_i,
  output logic [7:0] width_o
);

  logic [7:0] width_q;
  logic [7:0] width_d;
  logic [7:0] gap_s;
  logic [7:0] step_s;

  // Bounded step toward the target; the step never exceeds the remaining gap.
  always_comb begin
    gap_s   = 8'd0;
    step_s  = 8'd0;
    width_d = width_q;
    if (target_i >= width_q) begin
      gap_s = target_i - width_q;
    end else begin
      gap_s = width_q - target_i;
    end
    if (gap_s > MAX_STEP) begin
      step_s = MAX_STEP;
    end else begin
      step_s = gap_s;
    end
    if (force_neutral_i) begin
      width_d = NEUTRAL;
    end else if (!tick_i) begin
      width_d = width_q;
    end else if (target_i >= width_q) begin
      width_d = width_q + step_s;
    end else begin
      width_d = width_q - step_s;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      width_q <= NEUTRAL;
    end else begin
      width_q <= width_d;
    end
  end

  assign width_o = width_q;

endmodule

// File: rtl/motor_command_arbiter.sv
// Chooses host / RC / failsafe / paused command source and feeds slew-limited
// widths to the two motor PWM generators once per frame.
module motor_command_arbiter
  import motor_command_arbiter_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES        = FRAME_CYCLES_20MS,
  parameter logic [7:0]  MAX_STEP            = 8'd8,
  parameter int unsigned HOST_TIMEOUT_FRAMES = 25,
  parameter logic [7:0]  OVERRIDE_THRESH     = 8'd192,
  parameter logic [7:0]  NEUTRAL             = NEUTRAL_WIDTH
) (
  input  logic                    clk_255kHz,
  input  logic                    reset,
  motor_command_arbiter_if.slave  bus
);

  localparam logic [12:0] FRAME_LAST = 13'(FRAME_CYCLES - 1);
  localparam logic [7:0]  TIMEOUT    = 8'(HOST_TIMEOUT_FRAMES);

  logic [12:0] frame_cnt_q, frame_cnt_d;
  logic        frame_tick_q;
  logic        tick_s;
  logic        host_alive_q, host_alive_d;
  logic [7:0]  host_frames_q, host_frames_d;
  logic [7:0]  host_left_q, host_left_d;
  logic [7:0]  host_right_q, host_right_d;
  source_t     source_q, source_d;
  logic        rc_override_s;
  logic [7:0]  target_left_s, target_right_s;
  logic [7:0]  width_left_s, width_right_s;

  // Frame timing, host liveness and the prioritised source choice.
  always_comb begin
    tick_s        = (frame_cnt_q == FRAME_LAST);
    frame_cnt_d   = frame_cnt_q;
    host_alive_d  = host_alive_q;
    host_frames_d = host_frames_q;
    host_left_d   = host_left_q;
    host_right_d  = host_right_q;
    source_d      = source_q;
    if (tick_s) begin
      frame_cnt_d = 13'd0;
    end else begin
      frame_cnt_d = frame_cnt_q + 13'd1;
    end
    // A strobe landing on the expiring tick keeps the host alive.
    if (bus.host_strobe) begin
      host_alive_d  = 1'b1;
      host_frames_d = 8'd0;
      host_left_d   = bus.host_left;
      host_right_d  = bus.host_right;
    end else if (tick_s) begin
      if (host_frames_q < TIMEOUT) begin
        host_frames_d = host_frames_q + 8'd1;
      end else begin
        host_frames_d = host_frames_q;
      end
      if (host_frames_d >= TIMEOUT) begin
        host_alive_d = 1'b0;
      end else begin
        host_alive_d = host_alive_q;
      end
    end else begin
      host_alive_d = host_alive_q;
    end
    rc_override_s = bus.rc_throttle_valid & bus.rc_steer_valid & bus.rc_mode_valid &
                    (bus.rc_mode >= OVERRIDE_THRESH);
    if (bus.pause) begin
      source_d = PAUSED;
    end else if (rc_override_s) begin
      source_d = RC;
    end else if (host_alive_q) begin
      source_d = HOST;
    end else begin
      source_d = FAILSAFE;
    end
  end

  // Per-source width targets.
  always_comb begin
    target_left_s  = NEUTRAL;
    target_right_s = NEUTRAL;
    case (source_q)
      HOST: begin
        target_left_s  = host_left_q;
        target_right_s = host_right_q;
      end
      RC: begin
        target_left_s  = rc_mix(bus.rc_throttle, bus.rc_steer, 1'b1);
        target_right_s = rc_mix(bus.rc_throttle, bus.rc_steer, 1'b0);
      end
      default: begin
        target_left_s  = NEUTRAL;
        target_right_s = NEUTRAL;
      end
    endcase
  end

  always_ff @(posedge clk_255kHz) begin
    if (reset) begin
      frame_cnt_q   <= 13'd0;
      frame_tick_q  <= 1'b0;
      host_alive_q  <= 1'b0;
      host_frames_q <= 8'd0;
      host_left_q   <= NEUTRAL;
      host_right_q  <= NEUTRAL;
      source_q      <= FAILSAFE;
    end else begin
      frame_cnt_q   <= frame_cnt_d;
      frame_tick_q  <= tick_s;
      host_alive_q  <= host_alive_d;
      host_frames_q <= host_frames_d;
      host_left_q   <= host_left_d;
      host_right_q  <= host_right_d;
      source_q      <= source_d;
    end
  end

  motor_command_arbiter_slew_limiter #(.MAX_STEP(MAX_STEP), .NEUTRAL(NEUTRAL)) u_slew_left (
    .clk_i           (clk_255kHz),
    .reset_i         (reset),
    .tick_i          (tick_s),
    .force_neutral_i (bus.pause),
    .target_i        (target_left_s),
    .width_o         (width_left_s)
  );

  motor_command_arbiter_slew_limiter #(.MAX_STEP(MAX_STEP), .NEUTRAL(NEUTRAL)) u_slew_right (
    .clk_i           (clk_255kHz),
    .reset_i         (reset),
    .tick_i          (tick_s),
    .force_neutral_i (bus.pause),
    .target_i        (target_right_s),
    .width_o         (width_right_s)
  );

  assign bus.width_left  = width_left_s;
  assign bus.width_right = width_right_s;
  assign bus.source      = source_q;
  assign bus.frame_tick  = frame_tick_q;

endmodule
